uart_tx_buf: RTL and testbench

UART transmitter: 8N1 frames (start 0, 8 data bits LSB first, stop 1) serialised on TX at one bit per BAUD_DIV clocks. It is the transmit end of the link whose receiver samples at the 2604-clock bit period.
- Includes a 1-entry holding register, so a second byte can be queued while a frame is on the wire.
- Back-to-back frames go out with no idle gap.
- Sticky tx_done / clr_tx_done completion handshake.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/uart_tx_buf.sv | 125 ++++++++++++
 tb/tb_uart_tx_buf.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period and frame geometry.
// The helper builds an 8N1 frame laid out LSB-first for a right-shifting register.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XMIT = 1'b1
  } state_t;

  localparam int UART_BAUD_DIV   = 2604;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_BIT_CNT_W  = 4;

  // Start bit sits in bit 0 so it reaches the line first; stop bit is the MSB.
  function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..DIV-1 while enabled and pulses o_tc on the last count.
// Shared with the receive path, which needs the same terminal-count timing.
module uart_baud_cnt #(
  parameter int DIV = 2604
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames
// and a sticky completion flag (tx_done) cleared by clr_tx_done or a new accepted byte.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  input  logic       clr_tx_done,
  output logic       TX,
  output logic       tx_rdy,
  output logic       tx_done,
  output logic       busy
);

  localparam logic [UART_BIT_CNT_W-1:0] LAST_BIT = UART_BIT_CNT_W'(UART_FRAME_BITS - 1);

  state_t                      r_state,     w_state_nxt;
  logic [UART_FRAME_BITS-1:0]  r_shift,     w_shift_nxt;
  logic [UART_BIT_CNT_W-1:0]   r_bit_cnt,   w_bit_cnt_nxt;
  logic [7:0]                  r_hold,      w_hold_nxt;
  logic                        r_hold_vld,  w_hold_vld_nxt;
  logic                        r_tx_done,   w_tx_done_nxt;
  logic                        r_tx,        w_tx_nxt;

  logic w_accept;
  logic w_start;
  logic w_baud_tc;
  logic w_frame_end;

  assign tx_rdy      = ~r_hold_vld;
  assign w_accept    = trmt && tx_rdy;
  assign w_start     = (r_state == IDLE) && w_accept;
  assign w_frame_end = (r_state == XMIT) && w_baud_tc && (r_bit_cnt == LAST_BIT);

  uart_baud_cnt #(
    .DIV (BAUD_DIV)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_state == XMIT),
    .i_clr (w_start),
    .o_tc  (w_baud_tc)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_hold_nxt     = r_hold;
    w_hold_vld_nxt = r_hold_vld;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shift_nxt   = uart_frame(tx_data);
          w_bit_cnt_nxt = '0;
          w_state_nxt   = XMIT;
        end
      end
      XMIT: begin
        if (w_frame_end) begin
          // Chain the next frame straight in so its start bit follows the stop bit.
          w_bit_cnt_nxt = '0;
          if (r_hold_vld) begin
            w_shift_nxt    = uart_frame(r_hold);
            w_hold_vld_nxt = 1'b0;
          end else if (w_accept) begin
            w_shift_nxt = uart_frame(tx_data);
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (w_baud_tc) begin
            w_shift_nxt   = {1'b1, r_shift[UART_FRAME_BITS-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
          if (w_accept) begin
            w_hold_nxt     = tx_data;
            w_hold_vld_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Completion beats both clear sources when they coincide.
    if (w_frame_end) begin
      w_tx_done_nxt = 1'b1;
    end else if (clr_tx_done || w_accept) begin
      w_tx_done_nxt = 1'b0;
    end else begin
      w_tx_done_nxt = r_tx_done;
    end

    w_tx_nxt = (w_state_nxt == XMIT) ? w_shift_nxt[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_hold_vld <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_tx_done  <= w_tx_done_nxt;
      r_tx       <= w_tx_nxt;
    end
    // Payload registers are qualified by state/hold_vld and need no reset.
    r_shift <= w_shift_nxt;
    r_hold  <= w_hold_nxt;
  end

  assign TX      = r_tx;
  assign tx_done = r_tx_done;
  assign busy    = (r_state == XMIT);

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: a full-rate instance (BAUD_DIV=2604) for exact frame timing and
// a fast instance (BAUD_DIV=16) decoded by a serial monitor against a byte scoreboard.
module tb_uart_tx_buf;

  localparam int SDIV = 2604;
  localparam int FDIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       s_trmt = 1'b0, s_clr = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_tx, s_rdy, s_done, s_busy;

  logic       f_trmt = 1'b0, f_clr = 1'b0;
  logic [7:0] f_data = 8'h00;
  logic       f_tx, f_rdy, f_done, f_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_frames = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_tx_buf #(.BAUD_DIV(SDIV)) u_slow (
    .clk(clk), .rst(rst), .trmt(s_trmt), .tx_data(s_data), .clr_tx_done(s_clr),
    .TX(s_tx), .tx_rdy(s_rdy), .tx_done(s_done), .busy(s_busy)
  );

  uart_tx_buf #(.BAUD_DIV(FDIV)) u_fast (
    .clk(clk), .rst(rst), .trmt(f_trmt), .tx_data(f_data), .clr_tx_done(f_clr),
    .TX(f_tx), .tx_rdy(f_rdy), .tx_done(f_done), .busy(f_busy)
  );

  // Serial decoder on the fast line: samples mid-bit and checks against the scoreboard.
  initial begin
    logic       m_act;
    int         m_cnt;
    int         m_k;
    logic [7:0] m_sh;
    logic [7:0] m_exp;
    m_act = 1'b0;
    m_cnt = 0;
    m_sh  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        if (f_tx == 1'b0) begin
          m_act = 1'b1;
          m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt % FDIV == FDIV / 2) begin
          m_k = m_cnt / FDIV;
          if (m_k >= 1 && m_k <= 8) begin
            m_sh[m_k-1] = f_tx;
          end else if (m_k == 9) begin
            m_act = 1'b0;
            n_frames++;
            n_tests++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL rx_frame: got byte %02h stop %b, required no frame", m_sh, f_tx);
            end else begin
              m_exp = q.pop_front();
              if ({f_tx, m_sh} !== {1'b1, m_exp}) begin
                n_fail++;
                $display("FAIL rx_byte: got %02h stop %b, required %02h stop 1", m_sh, f_tx, m_exp);
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!f_busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b pending=%0d after %0d cycles, required idle", f_busy, q.size(), max_cycles);
    end
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < 100 && !bad; c++) begin
      n_tests++;
      if ({f_tx, f_rdy, f_done, f_busy, s_tx, s_rdy, s_done, s_busy} !== 8'b1100_1100) begin
        n_fail++;
        bad = 1'b1;
        $display("FAIL reset_idle c=%0d: got fast tx/rdy/done/busy=%b%b%b%b slow=%b%b%b%b, required 1100 1100",
                 c, f_tx, f_rdy, f_done, f_busy, s_tx, s_rdy, s_done, s_busy);
      end
      tick();
    end
  endtask

  task automatic test_frame_full_rate();
    logic [9:0] fr;
    logic       exp;
    fr = {1'b1, 8'hA5, 1'b0};
    s_trmt = 1'b1;
    s_data = 8'hA5;
    tick();
    s_trmt = 1'b0;
    for (int c = 1; c <= 10 * SDIV + 1; c++) begin
      if (c <= 10 * SDIV) begin
        exp = fr[(c-1)/SDIV];
        if ((c - 1) % SDIV == 0 || c % SDIV == 0) begin
          n_tests++;
          if (s_tx !== exp) begin
            n_fail++;
            $display("FAIL slow_tx c=%0d: got %b, required %b", c, s_tx, exp);
          end
        end
      end
      if (c == 10 * SDIV) begin
        n_tests++;
        if ({s_done, s_busy} !== 2'b01) begin
          n_fail++;
          $display("FAIL slow_last_stop: got done/busy=%b%b, required 01", s_done, s_busy);
        end
      end
      if (c == 10 * SDIV + 1) begin
        n_tests++;
        if ({s_tx, s_done, s_busy} !== 3'b110) begin
          n_fail++;
          $display("FAIL slow_frame_end: got tx/done/busy=%b%b%b, required 110", s_tx, s_done, s_busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int base = n_frames;
    f_trmt = 1'b1; f_data = 8'h3C; q.push_back(8'h3C);
    for (int c = 1; c <= 170; c++) begin
      tick();
      f_trmt = 1'b0;
      if (c == 20) begin
        n_tests++;
        if (f_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_rdy_before_hold: got %b, required 1", f_rdy);
        end
        f_trmt = 1'b1; f_data = 8'hC3; q.push_back(8'hC3);
      end
      if (c == 21 || c == 160) begin
        n_tests++;
        if (f_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_rdy_held c=%0d: got %b, required 0", c, f_rdy);
        end
      end
      if (c == 160) begin
        n_tests++;
        if (f_tx !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_stop: got %b, required 1", f_tx);
        end
      end
      if (c == 161) begin
        n_tests++;
        if ({f_tx, f_rdy, f_busy, f_done} !== 4'b0111) begin
          n_fail++;
          $display("FAIL b2b_second_start: got tx/rdy/busy/done=%b%b%b%b, required 0111", f_tx, f_rdy, f_busy, f_done);
        end
      end
    end
    wait_idle(400);
    n_tests++;
    if (n_frames !== base + 2) begin
      n_fail++;
      $display("FAIL b2b_frames: got %0d, required %0d", n_frames - base, 2);
    end
  endtask

  task automatic test_drop_when_full();
    int base = n_frames;
    tick();
    f_trmt = 1'b1; f_data = 8'h3C; q.push_back(8'h3C);
    for (int c = 1; c <= 40; c++) begin
      tick();
      f_trmt = 1'b0;
      if (c == 20) begin
        f_trmt = 1'b1; f_data = 8'hC3; q.push_back(8'hC3);
      end
      if (c == 30) begin
        n_tests++;
        if (f_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL drop_rdy: got %b, required 0", f_rdy);
        end
        f_trmt = 1'b1; f_data = 8'hFF;
      end
    end
    wait_idle(400);
    repeat (60) tick();
    n_tests++;
    if (n_frames !== base + 2) begin
      n_fail++;
      $display("FAIL drop_frames: got %0d, required %0d", n_frames - base, 2);
    end
  endtask

  task automatic test_frame_end_accept();
    int base = n_frames;
    tick();
    f_trmt = 1'b1; f_data = 8'h12; q.push_back(8'h12);
    for (int c = 1; c <= 161; c++) begin
      tick();
      f_trmt = 1'b0;
      if (c == 160) begin
        n_tests++;
        if (f_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL fe_accept_rdy: got %b, required 1", f_rdy);
        end
        f_trmt = 1'b1; f_data = 8'h34; q.push_back(8'h34);
      end
      if (c == 161) begin
        n_tests++;
        if ({f_tx, f_busy, f_done, f_rdy} !== 4'b0111) begin
          n_fail++;
          $display("FAIL fe_accept_start: got tx/busy/done/rdy=%b%b%b%b, required 0111", f_tx, f_busy, f_done, f_rdy);
        end
      end
    end
    wait_idle(400);
    n_tests++;
    if (n_frames !== base + 2) begin
      n_fail++;
      $display("FAIL fe_accept_frames: got %0d, required %0d", n_frames - base, 2);
    end
  endtask

  task automatic test_done_clear();
    tick();
    f_trmt = 1'b1; f_data = 8'h81; q.push_back(8'h81);
    for (int c = 1; c <= 162; c++) begin
      tick();
      f_trmt = 1'b0;
      if (c == 1 || c == 160) begin
        n_tests++;
        if (f_done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_low c=%0d: got %b, required 0", c, f_done);
        end
      end
      if (c == 160) f_clr = 1'b1;
      if (c == 161) begin
        n_tests++;
        if ({f_done, f_busy} !== 2'b10) begin
          n_fail++;
          $display("FAIL done_set_wins: got done/busy=%b%b, required 10", f_done, f_busy);
        end
      end
      if (c == 162) begin
        n_tests++;
        if (f_done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_cleared: got %b, required 0", f_done);
        end
        f_clr = 1'b0;
      end
    end
    wait_idle(100);
  endtask

  task automatic test_reset_mid_frame();
    int base = n_frames;
    bit saw_low = 1'b0;
    tick();
    f_trmt = 1'b1; f_data = 8'h55; q.push_back(8'h55);
    for (int c = 1; c <= 51; c++) begin
      tick();
      f_trmt = 1'b0;
      if (c == 20) begin
        f_trmt = 1'b1; f_data = 8'hAA; q.push_back(8'hAA);
      end
      if (c == 50) rst = 1'b1;
      if (c == 51) begin
        rst = 1'b0;
        n_tests++;
        if ({f_tx, f_rdy, f_busy, f_done} !== 4'b1100) begin
          n_fail++;
          $display("FAIL rst_mid: got tx/rdy/busy/done=%b%b%b%b, required 1100", f_tx, f_rdy, f_busy, f_done);
        end
        q.delete();
      end
    end
    for (int c = 0; c < 300; c++) begin
      if (f_tx !== 1'b1) saw_low = 1'b1;
      tick();
    end
    n_tests++;
    if (saw_low || n_frames !== base) begin
      n_fail++;
      $display("FAIL rst_no_more_frames: got line_low=%b frames=%0d, required 0 and 0", saw_low, n_frames - base);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_full_rate();
    test_back_to_back();
    test_drop_when_full();
    test_frame_end_accept();
    test_done_clear();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
